// File: rtl/rx_sequencer.sv
// rx_sequencer: control sequencer for a serial receiver. Detects the start
// edge, times each bit period, strobes an external shift register in the
// middle of every data bit, checks the stop bit, and manages the receive
// buffer handshake (data_ready / data_read) with framing and overrun flags.
// Consumer handshake: load_buffer marks a new word; data_ready stays high
// until a data_read cycle that is not also a LOAD cycle clears it.
module rx_sequencer #(
   parameter int NUM_BITS   = 8,
   parameter int BIT_PERIOD = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   input  logic       data_read,
   output logic       shift_strobe,
   output logic       load_buffer,
   output logic       data_ready,
   output logic       framing_error,
   output logic       overrun_error,
   output logic       busy,
   output logic [2:0] state_dbg_o
);

   localparam int HALF = BIT_PERIOD / 2;
   localparam int TW   = $clog2(BIT_PERIOD);
   localparam int CW   = $clog2(NUM_BITS + 1);

   localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
   localparam logic [TW-1:0] T_MID  = TW'(HALF - 1);
   localparam logic [CW-1:0] C_LAST = CW'(NUM_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_LOAD  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            prev_in_q;
   logic            ready_q, ferr_q, ovr_q;

   logic            start_edge;
   logic            stop_bad;
   logic            timer_last;

   // Edge and end-of-bit qualifiers shared by next-state and flag logic.
   assign start_edge = (state_q == S_IDLE) && prev_in_q && !serial_in;
   assign timer_last = (timer_q == T_LAST);
   assign stop_bad   = (state_q == S_STOP) && timer_last && !serial_in;

   // State register with timer, bit counter and line history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         cnt_q     <= '0;
         prev_in_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         cnt_q     <= cnt_d;
         prev_in_q <= serial_in;
      end
   end

   // Next-state logic: timer runs outside IDLE/LOAD and wraps per bit period.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (start_edge) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            timer_d = timer_q + TW'(1);
            if (timer_q == T_MID) begin
               // A line back high at mid start bit is a glitch, not a frame.
               state_d = serial_in ? S_IDLE : S_DATA;
               timer_d = '0;
            end
         end
         S_DATA: begin
            timer_d = timer_last ? '0 : timer_q + TW'(1);
            if (timer_last) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == C_LAST) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            timer_d = timer_last ? '0 : timer_q + TW'(1);
            if (timer_last) begin
               state_d = serial_in ? S_LOAD : S_IDLE;
            end
         end
         S_LOAD: begin
            timer_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the current state and timer.
   always_comb begin
      shift_strobe = (state_q == S_DATA) && timer_last;
      load_buffer  = (state_q == S_LOAD);
      busy         = (state_q != S_IDLE);
      state_dbg_o  = state_q;
   end

   // Status flags: framing error per frame, buffer valid and sticky overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (start_edge) begin
            ferr_q <= 1'b0;
         end else if (stop_bad) begin
            ferr_q <= 1'b1;
         end
         if (state_q == S_LOAD) begin
            // A read coinciding with the load consumes the old word, so it
            // is not an overrun; the new word stays valid.
            ready_q <= 1'b1;
            if (ready_q && !data_read) begin
               ovr_q <= 1'b1;
            end
         end else if (data_read) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
         end
      end
   end

   assign data_ready    = ready_q;
   assign framing_error = ferr_q;
   assign overrun_error = ovr_q;

endmodule

// File: doc/rx_sequencer.md
RX_SEQUENCER -- requirements
Module: rx_sequencer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, giving data bits per frame (>= 2).
REQ-002 SHALL have parameter BIT_PERIOD, default 10, giving clocks per serial bit (even, >= 4); HALF = BIT_PERIOD/2.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port serial_in, input, 1, line data, already synchronous to clk, idle high.
REQ-006 SHALL have port data_read, input, 1, consumer acknowledge of the buffered word.
REQ-007 SHALL have port shift_strobe, output, 1, shift-enable pulse to the external serial-to-parallel shift register.
REQ-008 SHALL have port load_buffer, output, 1, one-cycle pulse to copy the shift register into the receive buffer.
REQ-009 SHALL have port data_ready, output, 1, buffered word valid.
REQ-010 SHALL have port framing_error, output, 1, last frame had a bad stop bit.
REQ-011 SHALL have port overrun_error, output, 1, a frame was loaded while data_ready was set.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, LOAD.
REQ-014 SHALL keep a registered copy prev_in of serial_in; start edge = prev_in==1 and serial_in==0 while in IDLE.
REQ-015 On start edge: next state START, timer = 0, bit counter = 0, framing_error cleared.
REQ-016 Timer SHALL be ceil(log2(BIT_PERIOD)) bits, increment by 1 each cycle outside IDLE/LOAD, and wrap to 0 after BIT_PERIOD-1 in DATA/STOP.
REQ-017 START: when timer == HALF-1, serial_in==1 -> IDLE (false start, no other output change); serial_in==0 -> DATA with timer = 0.
REQ-018 DATA: shift_strobe SHALL be high combinationally for exactly the one cycle where timer == BIT_PERIOD-1, and low otherwise.
REQ-019 Each shift_strobe SHALL increment the bit counter; the cycle after the NUM_BITS-th strobe the state SHALL be STOP with timer = 0.
REQ-020 STOP: at timer == BIT_PERIOD-1, serial_in==1 -> LOAD; serial_in==0 -> IDLE with framing_error = 1 and no load.
REQ-021 LOAD: load_buffer high for exactly that one cycle, then IDLE unconditionally.
REQ-022 data_ready SHALL be set on the edge ending the LOAD cycle and cleared on the edge where data_read==1 with no LOAD.
REQ-023 LOAD while data_ready==1 and data_read==0 SHALL set overrun_error; overrun_error SHALL be sticky until data_read==1.
REQ-024 LOAD and data_read in the same cycle SHALL leave data_ready = 1, overrun_error unchanged (not set).
REQ-025 Start edges SHALL be ignored in every state except IDLE; line activity in DATA affects only the sampled bit value.
REQ-026 Latency SHALL be as follows for start edge detected at cycle c: strobes at c+HALF+BIT_PERIOD+k*BIT_PERIOD (k = 0..NUM_BITS-1); load_buffer at c+HALF+(NUM_BITS+1)*BIT_PERIOD+1.

Reset
REQ-027 rst high SHALL immediately force state IDLE; timer, bit counter, and all outputs 0; prev_in = 1.
REQ-028 rst asserted mid-frame SHALL abort the frame with no load_buffer or strobe; after release, reception restarts only on a new start edge.

Verification (NUM_BITS=8, BIT_PERIOD=10)
REQ-029 Valid frame 0xA5 LSB-first, stop=1, edge at c -> strobes at c+15, c+25 ... c+85; load_buffer at c+96; data_ready=1 from c+97; stp register = 0xA5.
REQ-030 serial_in low for 2 cycles then high -> return to IDLE at c+6, zero strobes, busy low, data_ready 0.
REQ-031 Frame with stop=0 -> framing_error=1 from c+96, no load_buffer, data_ready stays 0; next start edge clears framing_error.
REQ-032 Two valid frames, no data_read -> overrun_error=1 after second LOAD; one data_read pulse -> data_ready=0, overrun_error=0.
REQ-033 data_read asserted in the second frame's LOAD cycle -> data_ready stays 1, overrun_error stays 0.
REQ-034 rst pulsed at c+40 -> all outputs 0 immediately, no further strobes; fresh frame afterward received correctly.
